// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
package mem_stage_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  localparam int DEFAULT_DEPTH   = 256;
  localparam int DEFAULT_LATENCY = 2;

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM-to-MEM/WB bundle: master is the upstream driver, slave is mem_stage.
interface mem_stage_if;

  logic        valid_in;
  logic [1:0]  wb_ctl_in;
  logic        branch_in;
  logic        memread_in;
  logic        memwrite_in;
  logic        zero_in;
  logic [31:0] alu_result_in;
  logic [31:0] wdata_in;
  logic [4:0]  dest_in;

  logic        pcsrc;
  logic        stall;
  logic        valid_out;
  logic [1:0]  wb_ctl_out;
  logic [31:0] read_data_out;
  logic [31:0] alu_result_out;
  logic [4:0]  dest_out;
  logic        misalign_out;

  modport master (
    output valid_in, wb_ctl_in, branch_in, memread_in, memwrite_in, zero_in,
           alu_result_in, wdata_in, dest_in,
    input  pcsrc, stall, valid_out, wb_ctl_out, read_data_out, alu_result_out,
           dest_out, misalign_out
  );

  modport slave (
    input  valid_in, wb_ctl_in, branch_in, memread_in, memwrite_in, zero_in,
           alu_result_in, wdata_in, dest_in,
    output pcsrc, stall, valid_out, wb_ctl_out, read_data_out, alu_result_out,
           dest_out, misalign_out
  );

endinterface

// File: rtl/mem_stage_data_mem.sv
// Single-port DEPTH x 32 word array; write and read both take effect at the edge.
// Read is registered and held between read enables; read returns pre-write data.
module data_mem #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: 1 cycle for non-memory ops, LATENCY+1 cycles for loads/stores; stalls upstream meanwhile.
// Optional MEM_STAGE_ALIGN_CHECK_EN flags misaligned accesses instead of performing them.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic       clk,
  input  logic       rst_n,
  mem_stage_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          valid_q, valid_d;
  logic [1:0]    wb_q, wb_d;
  logic [31:0]   alu_q, alu_d;
  logic [4:0]    dest_q, dest_d;
  logic          rd_vld_q, rd_vld_d;
  logic          mis_q, mis_d;

  logic          mem_op;
  logic          misalign;
  logic          stall_c;
  logic          mem_we;
  logic          mem_re;
  logic [31:0]   mem_rdata;

  assign mem_op = bus.valid_in & (bus.memread_in | bus.memwrite_in);

`ifdef MEM_STAGE_ALIGN_CHECK_EN
  assign misalign = mem_op & (|bus.alu_result_in[1:0]);
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    valid_d  = valid_q;
    wb_d     = wb_q;
    alu_d    = alu_q;
    dest_d   = dest_q;
    rd_vld_d = rd_vld_q;
    mis_d    = 1'b0;
    stall_c  = 1'b0;
    mem_we   = 1'b0;
    mem_re   = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_op && !misalign) begin
          state_d = ACCESS;
          cnt_d   = CNT_INIT;
          addr_d  = bus.alu_result_in[AW+1:2];
          valid_d = 1'b0;
          stall_c = 1'b1;
        end else begin
          valid_d  = bus.valid_in;
          wb_d     = bus.wb_ctl_in;
          alu_d    = bus.alu_result_in;
          dest_d   = bus.dest_in;
          rd_vld_d = 1'b0;
          mis_d    = misalign;
        end
      end
      ACCESS: begin
        valid_d = 1'b0;
        if (cnt_q != '0) begin
          cnt_d   = cnt_q - 1'b1;
          stall_c = 1'b1;
        end else begin
          // Upstream has held EX/MEM for the whole access, so inputs are still current.
          mem_re   = 1'b1;
          mem_we   = bus.memwrite_in;
          rd_vld_d = 1'b1;
          valid_d  = 1'b1;
          wb_d     = bus.wb_ctl_in;
          alu_d    = bus.alu_result_in;
          dest_d   = bus.dest_in;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      valid_q  <= 1'b0;
      wb_q     <= '0;
      alu_q    <= '0;
      dest_q   <= '0;
      rd_vld_q <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      valid_q  <= valid_d;
      wb_q     <= wb_d;
      alu_q    <= alu_d;
      dest_q   <= dest_d;
      rd_vld_q <= rd_vld_d;
      mis_q    <= mis_d;
    end
  end

  data_mem #(.DEPTH(DEPTH), .AW(AW)) u_data_mem (
    .clk   (clk),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (addr_q),
    .wdata (bus.wdata_in),
    .rdata (mem_rdata)
  );

  // The array has no reset, so load data is gated by a resettable qualifier.
  assign bus.read_data_out  = rd_vld_q ? mem_rdata : '0;
  assign bus.pcsrc          = bus.valid_in & bus.branch_in & bus.zero_in;
  assign bus.stall          = stall_c;
  assign bus.valid_out      = valid_q;
  assign bus.wb_ctl_out     = wb_q;
  assign bus.alu_result_out = alu_q;
  assign bus.dest_out       = dest_q;
  assign bus.misalign_out   = mis_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with DEPTH=256, LATENCY=2.
module tb_mem_stage;

  localparam int LAT = 2;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  mem_stage_if ifc ();

  mem_stage #(.DEPTH(256), .LATENCY(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    ifc.valid_in      = 1'b0;
    ifc.wb_ctl_in     = 2'b00;
    ifc.branch_in     = 1'b0;
    ifc.memread_in    = 1'b0;
    ifc.memwrite_in   = 1'b0;
    ifc.zero_in       = 1'b0;
    ifc.alu_result_in = 32'h0;
    ifc.wdata_in      = 32'h0;
    ifc.dest_in       = 5'd0;
  endtask

  // Called 1ns after a rising edge; returns 1ns after the edge that registers the result.
  task automatic do_mem(input string tag, input logic [31:0] a, input logic [31:0] wd,
                        input logic rd, input logic wr, input logic [4:0] d,
                        input logic chk_rd, input logic [31:0] exp_rd);
    int n;
    ifc.valid_in      = 1'b1;
    ifc.memread_in    = rd;
    ifc.memwrite_in   = wr;
    ifc.alu_result_in = a;
    ifc.wdata_in      = wd;
    ifc.dest_in       = d;
    ifc.wb_ctl_in     = rd ? 2'b11 : 2'b00;
    #1;
    n = 0;
    while (ifc.stall && n < 20) begin
      n++;
      @(posedge clk); #1;
    end
    check({tag, "_stall_cycles"}, n, LAT);
    check({tag, "_valid_final"}, {31'd0, ifc.valid_out}, 32'd0);
    @(posedge clk); #1;
    check({tag, "_valid_out"}, {31'd0, ifc.valid_out}, 32'd1);
    check({tag, "_alu_out"}, ifc.alu_result_out, a);
    check({tag, "_dest_out"}, {27'd0, ifc.dest_out}, {27'd0, d});
    if (chk_rd) check({tag, "_rdata"}, ifc.read_data_out, exp_rd);
    drive_idle();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, ifc.valid_out}, 32'd0);
    check("rst_rdata", ifc.read_data_out, 32'd0);
    check("rst_alu", ifc.alu_result_out, 32'd0);
    check("rst_dest_wb", {25'd0, ifc.dest_out, ifc.wb_ctl_out}, 32'd0);
    check("rst_stall", {31'd0, ifc.stall}, 32'd0);
    check("rst_misalign", {31'd0, ifc.misalign_out}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Non-memory pass-through
    ifc.valid_in      = 1'b1;
    ifc.alu_result_in = 32'h0000_0010;
    ifc.dest_in       = 5'd5;
    ifc.wb_ctl_in     = 2'b10;
    #1;
    check("pass_stall", {31'd0, ifc.stall}, 32'd0);
    @(posedge clk); #1;
    check("pass_valid", {31'd0, ifc.valid_out}, 32'd1);
    check("pass_alu", ifc.alu_result_out, 32'h10);
    check("pass_dest", {27'd0, ifc.dest_out}, 32'd5);
    check("pass_wb", {30'd0, ifc.wb_ctl_out}, 32'd2);
    check("pass_rdata", ifc.read_data_out, 32'd0);

    // Branch resolution is combinational
    ifc.branch_in = 1'b1;
    ifc.zero_in   = 1'b1;
    #1;
    check("br_taken", {31'd0, ifc.pcsrc}, 32'd1);
    ifc.zero_in = 1'b0;
    #1;
    check("br_not_taken", {31'd0, ifc.pcsrc}, 32'd0);
    drive_idle();
    @(posedge clk); #1;
    check("idle_valid", {31'd0, ifc.valid_out}, 32'd0);

    do_mem("st40", 32'h40, 32'hDEAD_BEEF, 1'b0, 1'b1, 5'd0, 1'b0, 32'h0);
    do_mem("ld40", 32'h40, 32'h0, 1'b1, 1'b0, 5'd7, 1'b1, 32'hDEAD_BEEF);
    check("ld40_wb", {30'd0, ifc.wb_ctl_out}, 32'd3);

    do_mem("st44", 32'h44, 32'h1111_1111, 1'b0, 1'b1, 5'd0, 1'b0, 32'h0);
    do_mem("rw44", 32'h44, 32'h2222_2222, 1'b1, 1'b1, 5'd3, 1'b1, 32'h1111_1111);
    do_mem("ld44", 32'h44, 32'h0, 1'b1, 1'b0, 5'd4, 1'b1, 32'h2222_2222);

    do_mem("st400", 32'h400, 32'h0000_1234, 1'b0, 1'b1, 5'd0, 1'b0, 32'h0);
    do_mem("ld000", 32'h000, 32'h0, 1'b1, 1'b0, 5'd9, 1'b1, 32'h0000_1234);

`ifdef MEM_STAGE_ALIGN_CHECK_EN
    ifc.valid_in      = 1'b1;
    ifc.memread_in    = 1'b1;
    ifc.alu_result_in = 32'h41;
    ifc.dest_in       = 5'd2;
    #1;
    check("mis_stall", {31'd0, ifc.stall}, 32'd0);
    @(posedge clk); #1;
    check("mis_flag", {31'd0, ifc.misalign_out}, 32'd1);
    check("mis_valid", {31'd0, ifc.valid_out}, 32'd1);
    check("mis_rdata", ifc.read_data_out, 32'd0);
    drive_idle();
    @(posedge clk); #1;
    check("mis_clear", {31'd0, ifc.misalign_out}, 32'd0);
`else
    do_mem("ld41", 32'h41, 32'h0, 1'b1, 1'b0, 5'd2, 1'b1, 32'hDEAD_BEEF);
    check("ld41_misalign", {31'd0, ifc.misalign_out}, 32'd0);
`endif

    // Abandon a store mid-access; the location must keep its old contents.
    ifc.valid_in      = 1'b1;
    ifc.memwrite_in   = 1'b1;
    ifc.alu_result_in = 32'h40;
    ifc.wdata_in      = 32'hCAFE_F00D;
    @(posedge clk); #1;
    check("abort_stall", {31'd0, ifc.stall}, 32'd1);
    drive_idle();
    rst_n = 1'b0;
    #1;
    check("abort_valid", {31'd0, ifc.valid_out}, 32'd0);
    check("abort_rdata", ifc.read_data_out, 32'd0);
    check("abort_alu", ifc.alu_result_out, 32'd0);
    check("abort_stall_low", {31'd0, ifc.stall}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_mem("ld40_after_abort", 32'h40, 32'h0, 1'b1, 1'b0, 5'd1, 1'b1, 32'hDEAD_BEEF);

    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage directly downstream of the EX/MEM register. Consumes the EX/MEM control and data outputs, performs the data-memory read or write against an internal word-addressed array with a configurable multi-cycle latency, and resolves the branch decision. It stalls upstream while an access is in flight, and registers its results as the MEM/WB pipeline register for the write-back stage.

## Interface
Parameters:
- DEPTH, 256, number of 32-bit data-memory words; power of two.
- LATENCY, 2, cycles a memory access occupies after acceptance; minimum 1.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- valid_in  in  1  EX/MEM holds a valid instruction.
- wb_ctl_in  in  2  write-back control; bit1 regwrite, bit0 memtoreg.
- branch_in, memread_in, memwrite_in  in  1 each  memory-stage control.
- zero_in  in  1  ALU zero flag.
- alu_result_in  in  32  ALU result; serves as byte address for memory ops.
- wdata_in  in  32  store data (register read data 2).
- dest_in  in  5  destination register number.
- pcsrc  out  1  branch taken, combinational.
- stall  out  1  upstream must hold EX/MEM contents this cycle.
- valid_out  out  1  MEM/WB holds a valid instruction.
- wb_ctl_out  out  2  registered wb_ctl_in.
- read_data_out  out  32  registered load data.
- alu_result_out  out  32  registered alu_result_in.
- dest_out  out  5  registered dest_in.
- misalign_out  out  1  misaligned access flag (see Configuration).

## Operation
- mem_op = valid_in & (memread_in | memwrite_in).
- pcsrc = valid_in & branch_in & zero_in; independent of stall and FSM state.
- FSM states: IDLE, ACCESS. Down-counter cnt, width clog2(LATENCY).
- IDLE, no mem_op: at the edge, register wb_ctl/alu_result/dest, valid_out <= valid_in, read_data_out <= 0; stay IDLE.
- IDLE, mem_op: latch word address alu_result_in[clog2(DEPTH)+1:2]; cnt <= LATENCY-1; valid_out <= 0; go to ACCESS.
- ACCESS, cnt != 0: cnt decrements; valid_out <= 0.
- ACCESS, cnt == 0 (final cycle): the write is committed if memwrite_in; read_data_out <= array[addr] (the value before any same-cycle write); MEM/WB fields are registered; valid_out <= 1; go to IDLE.
- stall = (IDLE & mem_op) | (ACCESS & cnt != 0).
- memread_in and memwrite_in both set: the write is performed, and read_data_out returns the old contents.
- Address bits above clog2(DEPTH)+1 are ignored, so addresses wrap modulo DEPTH words.
- Array contents are not cleared by reset.

## Timing
- Non-memory instruction: 1 cycle; results are valid on valid_out the cycle after presentation.
- Memory instruction presented at cycle T: stall is high T..T+LATENCY-1 and low at T+LATENCY. Results are registered at the end of T+LATENCY. Occupancy is LATENCY+1 cycles.
- A new instruction is accepted at T+LATENCY+1; back-to-back memory ops have no extra bubble beyond occupancy.
- Reset values: all outputs 0, state IDLE, cnt 0. pcsrc follows its inputs.
- Reset asserted mid-ACCESS: the access is abandoned, no write occurs, and outputs clear immediately.

## Configuration
- MEM_STAGE_ALIGN_CHECK_EN defined:
  - a mem_op in IDLE with alu_result_in[1:0] != 0 does not enter ACCESS and does not stall, and no write occurs;
  - at the edge, misalign_out <= 1, valid_out <= 1 and read_data_out <= 0, for one cycle;
  - misalign_out otherwise registers 0.
- Not defined: low address bits are ignored, and misalign_out is tied 0.

## Structure
- Package mem_stage_pkg holds:
  - the FSM state enum (IDLE, ACCESS);
  - WB control bit indices WB_REGWRITE=1 and WB_MEMTOREG=0;
  - the default DEPTH and LATENCY values.
- Sub-module data_mem: single-port synchronous word array (DEPTH x 32) with write enable and registered read. It has no reset.

## Test plan
- Reset mid-access: store issued, rst_n pulsed low during ACCESS -> all outputs 0 immediately, and a later load from that address shows the location unchanged.
- Non-memory pass-through: valid_in=1, alu_result_in=0x0000_0010, dest_in=5, wb_ctl_in=2'b10 -> next cycle valid_out=1, alu_result_out=0x10, dest_out=5, stall never high.
- Store then load, LATENCY=2:
  - store 0xDEADBEEF to 0x40 -> stall high 2 cycles, valid_out=1 on the 3rd edge;
  - load 0x40 -> read_data_out=0xDEADBEEF.
- Branch: branch_in=1, zero_in=1, valid_in=1 -> pcsrc=1 in the same cycle; zero_in=0 -> pcsrc=0.
- Wrap-around, DEPTH=256: store 0x1234 to 0x400, then load 0x000 -> 0x1234.
- Misalign, with the macro defined: load at 0x41 -> no stall, misalign_out=1 and read_data_out=0 for one cycle. Without the macro -> normal load of word 0x40.
